// File: rtl/fft_bitrev_reorder_pkg.sv
// fft_bitrev_reorder_pkg: shared read-FSM states, bit-reversal and sample slicing helpers
package fft_bitrev_reorder_pkg;
  typedef enum logic {IDLE, READ} rd_state_t;
  function automatic logic [31:0] bitrev(input logic [31:0] addr, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (i < width) r[i] = addr[width-1-i];
    return r;
  endfunction
  function automatic logic [31:0] re_part(input logic [63:0] d);
    return d[63:32];
  endfunction
  function automatic logic [31:0] im_part(input logic [63:0] d);
    return d[31:0];
  endfunction
endpackage

// File: rtl/fft_reorder_bank_ram.sv
// fft_reorder_bank_ram: simple dual-port RAM, one write port, one registered read port
//   clk               clock
//   we/wr_addr/wr_data write port
//   re/rd_addr        read request, data appears on rd_data after the next edge
module fft_reorder_bank_ram #(
  parameter int DW = 64,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: re-emits a bit-reversed FFT bin stream in natural order via ping-pong banks
//   clk, rst (async, active-high)
//   data_i_en/data_i   input bins, bit-reversed order, no backpressure
//   data_o_en/data_o   output bins, natural order; data_o is zero while data_o_en is low
//   frame_o_sop/eop    first/last output bin flags, present only with FFT_REORDER_FRAME_FLAGS_EN
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int DATA_NUM   = 1024,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_i_en,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  data_o_en,
  output logic [DATA_WIDTH-1:0] data_o
`ifdef FFT_REORDER_FRAME_FLAGS_EN
  ,
  output logic                  frame_o_sop,
  output logic                  frame_o_eop
`endif
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DATA_NUM - 1);
  logic [ADDR_WIDTH-1:0] wr_cnt, wr_addr, rd_addr, rd_addr_n;
  logic wr_bank, wr_last, rd_bank, rd_bank_n, ram_bank, ram_bank_n, rd_clr;
  logic [1:0] full, full_n;
  rd_state_t state, state_n;
  logic [DATA_WIDTH-1:0] ram_q;
  assign wr_last = data_i_en && wr_cnt == LAST;
  assign wr_addr = ADDR_WIDTH'(bitrev(32'(wr_cnt), ADDR_WIDTH));
  // rd_bank points at the next bank to drain and flips when the last address
  // is issued; ram_bank keeps the bank of the address currently on the RAM port.
  always_comb begin
    state_n = state;
    rd_addr_n = rd_addr;
    rd_bank_n = rd_bank;
    ram_bank_n = ram_bank;
    rd_clr = 1'b0;
    if (state == IDLE) begin
      if (full[rd_bank]) begin
        state_n = READ;
        rd_addr_n = '0;
        ram_bank_n = rd_bank;
      end
    end else if (rd_addr != LAST) begin
      rd_addr_n = rd_addr + 1'b1;
      rd_clr = rd_addr == LAST - 1'b1;
      rd_bank_n = rd_bank ^ rd_clr;
    end else if (full[rd_bank] || (wr_last && wr_bank == rd_bank)) begin
      rd_addr_n = '0;
      ram_bank_n = rd_bank;
    end else begin
      state_n = IDLE;
    end
  end
  always_comb begin
    full_n = full;
    if (wr_last) full_n[wr_bank] = 1'b1;
    if (rd_clr) full_n[rd_bank] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      wr_bank <= 1'b0;
      full <= '0;
      state <= IDLE;
      rd_addr <= '0;
      rd_bank <= 1'b0;
      ram_bank <= 1'b0;
      data_o_en <= 1'b0;
    end else begin
      if (data_i_en) wr_cnt <= wr_cnt + 1'b1;
      wr_bank <= wr_bank ^ wr_last;
      full <= full_n;
      state <= state_n;
      rd_addr <= rd_addr_n;
      rd_bank <= rd_bank_n;
      ram_bank <= ram_bank_n;
      data_o_en <= state == READ;
    end
  end
  assign data_o = data_o_en ? ram_q : '0;
`ifdef FFT_REORDER_FRAME_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_o_sop <= 1'b0;
      frame_o_eop <= 1'b0;
    end else begin
      frame_o_sop <= state == READ && rd_addr == '0;
      frame_o_eop <= state == READ && rd_addr == LAST;
    end
  end
`endif
  fft_reorder_bank_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH + 1)) u_ram (
    .clk     (clk),
    .we      (data_i_en),
    .wr_addr ({wr_bank, wr_addr}),
    .wr_data (data_i),
    .re      (state == READ),
    .rd_addr ({ram_bank, rd_addr}),
    .rd_data (ram_q)
  );
endmodule
